// File: rtl/readmemb_loader.sv
// Streams ASCII binary text (one word per line, MSB first) into sequential memory writes,
// mirroring the standard binary memory-load task, with sticky flags for short/long/illegal/overflowing lines.
module readmemb_loader #(
  parameter int WA = 8,
  parameter int WB = 8,
  parameter int AW = $clog2(WA)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          chr_vld,
  input  logic [7:0]    chr_dat,
  input  logic          chr_lst,
  output logic          chr_rdy,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [WB-1:0] mem_wdt,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   cnt,
  output logic          err_short,
  output logic          err_long,
  output logic          err_char,
  output logic          err_ovf
);
  localparam int BW = $clog2(WB + 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [WB-1:0] r_acc;
  logic [BW-1:0] r_bits;
  logic          r_bad;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [WB-1:0] r_wdt;
  logic [AW:0]   r_cnt;
  logic          r_es, r_el, r_ec, r_eo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (chr_vld && chr_lst) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    chr_rdy = (r_state == S_LOAD);
    busy    = (r_state == S_LOAD) || (r_state == S_FLUSH);
    done    = (r_state == S_DONE);
  end

  logic          w_hs, w_go, w_is_bit, w_ign, w_nl, w_bad_chr, w_bad_n, w_term, w_wr;
  logic [WB-1:0] w_acc_n;
  logic [BW-1:0] w_bits_n;

  assign w_hs      = chr_vld && chr_rdy;
  assign w_go      = (r_state == S_IDLE) && start;
  assign w_is_bit  = (chr_dat == 8'h30) || (chr_dat == 8'h31);
  assign w_ign     = (chr_dat == 8'h5F) || (chr_dat == 8'h20) || (chr_dat == 8'h09) || (chr_dat == 8'h0D);
  assign w_nl      = (chr_dat == 8'h0A);
  assign w_bad_chr = !w_is_bit && !w_ign && !w_nl;
  assign w_acc_n   = w_is_bit ? {r_acc[WB-2:0], chr_dat[0]} : r_acc;
  assign w_bits_n  = (w_is_bit && r_bits != BW'(WB + 1)) ? r_bits + 1'b1 : r_bits;
  assign w_bad_n   = r_bad || w_bad_chr;
  // The last character is decoded and its line closed in the same cycle, so the
  // flush write is already visible while the FSM sits in FLUSH.
  assign w_term    = w_hs && (w_nl || chr_lst);
  assign w_wr      = w_term && !w_bad_n && (w_bits_n != '0) && (w_bits_n <= BW'(WB))
                     && (r_cnt != (AW+1)'(WA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0; r_bits <= '0; r_bad <= 1'b0;
      r_we  <= 1'b0; r_adr <= '0; r_wdt <= '0; r_cnt <= '0;
      r_es  <= 1'b0; r_el <= 1'b0; r_ec <= 1'b0; r_eo <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_go) begin
        r_acc <= '0; r_bits <= '0; r_bad <= 1'b0;
        r_adr <= '0; r_cnt <= '0;
        r_es  <= 1'b0; r_el <= 1'b0; r_ec <= 1'b0; r_eo <= 1'b0;
      end else if (w_hs) begin
        if (w_bad_chr) r_ec <= 1'b1;
        if (w_term) begin
          r_acc <= '0; r_bits <= '0; r_bad <= 1'b0;
          if (w_wr) begin
            r_we  <= 1'b1;
            r_adr <= r_cnt[AW-1:0];
            r_wdt <= w_acc_n;
            r_cnt <= r_cnt + 1'b1;
            if (w_bits_n < BW'(WB)) r_es <= 1'b1;
          end else if (!w_bad_n && w_bits_n > BW'(WB)) begin
            r_el <= 1'b1;
          end else if (!w_bad_n && w_bits_n != '0) begin
            r_eo <= 1'b1;
          end
        end else begin
          r_acc <= w_acc_n; r_bits <= w_bits_n; r_bad <= w_bad_n;
        end
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_adr   = r_adr;
  assign mem_wdt   = r_wdt;
  assign cnt       = r_cnt;
  assign err_short = r_es;
  assign err_long  = r_el;
  assign err_char  = r_ec;
  assign err_ovf   = r_eo;
endmodule

// File: tb/tb_readmemb_loader.sv
// Random and directed text files fed to readmemb_loader; a line-level model predicts
// every write, the flags and the handshake/status outputs cycle by cycle.
module tb_readmemb_loader;
  localparam int WA = 8;
  localparam int WB = 8;
  localparam int AW = $clog2(WA);

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          chr_vld = 1'b0, chr_lst = 1'b0;
  logic [7:0]    chr_dat = 8'h00;
  logic          chr_rdy, mem_we, busy, done;
  logic [AW-1:0] mem_adr;
  logic [WB-1:0] mem_wdt;
  logic [AW:0]   cnt;
  logic          err_short, err_long, err_char, err_ovf;

  readmemb_loader #(.WA(WA), .WB(WB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chr_vld(chr_vld), .chr_dat(chr_dat),
    .chr_lst(chr_lst), .chr_rdy(chr_rdy), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdt(mem_wdt), .busy(busy), .done(done), .cnt(cnt), .err_short(err_short),
    .err_long(err_long), .err_char(err_char), .err_ovf(err_ovf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; int adr; int dat;} wr_t;
  wr_t expq[$];

  int m_acc, m_bits, m_words, m_done_due = 32'h7fffffff;
  bit m_bad, m_es, m_el, m_ec, m_eo, m_active;
  logic [7:0] shadow [WA];

  int n_chk = 0, n_pass = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // per-cycle comparison of every observable output against the model
  always @(negedge clk) begin
    bit exp_we;
    if (start && !m_active) foreach (shadow[k]) shadow[k] = 8'hAA;
    exp_we = (expq.size() > 0) && (expq[0].due <= cyc);
    chk("mem_we", int'(mem_we), int'(exp_we));
    if (exp_we) begin
      chk("mem_adr", int'(mem_adr), expq[0].adr);
      chk("mem_wdt", int'(mem_wdt), expq[0].dat);
      void'(expq.pop_front());
    end
    if (mem_we) shadow[mem_adr] = mem_wdt;
    chk("cnt", int'(cnt), m_words);
    chk("busy", int'(busy), int'(m_active && cyc != m_done_due));
    chk("done", int'(done), int'(cyc == m_done_due));
    chk("chr_rdy", int'(chr_rdy), int'(m_active && (cyc + 1 < m_done_due)));
    chk("err_short", int'(err_short), int'(m_es));
    chk("err_long", int'(err_long), int'(m_el));
    chk("err_char", int'(err_char), int'(m_ec));
    chk("err_ovf", int'(err_ovf), int'(m_eo));
  end

  task automatic model_clear_line();
    m_acc = 0; m_bits = 0; m_bad = 0;
  endtask

  task automatic model_end_line();
    if (m_bad || m_bits == 0) ;
    else if (m_bits > WB) m_el = 1;
    else if (m_words == WA) m_eo = 1;
    else begin
      if (m_bits < WB) m_es = 1;
      expq.push_back('{due: cyc, adr: m_words, dat: m_acc});
      m_words++;
    end
    model_clear_line();
  endtask

  task automatic model_char(byte c, bit lst);
    if (c == "0" || c == "1") begin
      m_acc = ((m_acc << 1) | (c == "1" ? 1 : 0)) & ((1 << WB) - 1);
      if (m_bits < WB + 1) m_bits++;
    end else if (c == "_" || c == " " || c == "\t" || c == "\r" || c == "\n") ;
    else begin
      m_bad = 1; m_ec = 1;
    end
    if (c == "\n" || lst) model_end_line();
    if (lst) m_done_due = cyc + 1;
  endtask

  task automatic send(byte c, bit lst);
    if ($urandom_range(0, 3) == 0) @(posedge clk) #1;
    chr_vld = 1'b1; chr_dat = c; chr_lst = lst;
    @(posedge clk) #1;
    model_char(c, lst);
    chr_vld = 1'b0; chr_lst = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    m_words = 0; m_es = 0; m_el = 0; m_ec = 0; m_eo = 0;
    model_clear_line();
    m_done_due = 32'h7fffffff; m_active = 1;
  endtask

  task automatic run_file(string s, bit start_in_done);
    start_load();
    for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
    @(posedge clk) #1;
    if (start_in_done) start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    m_active = 0;
  endtask

  function automatic string bin(int v, int n);
    string r = "";
    for (int b = n - 1; b >= 0; b--) r = {r, ((v >> b) & 1) != 0 ? "1" : "0"};
    return r;
  endfunction

  function automatic string lines(int n, int w);
    string r = "";
    for (int k = 0; k < n; k++) r = {r, bin(k, w), "\n"};
    return r;
  endfunction

  initial begin
    string s, t;
    foreach (shadow[k]) shadow[k] = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_adr", int'(mem_adr), 0);
    chk("rst_mem_wdt", int'(mem_wdt), 0);
    rst_n = 1'b1;
    @(posedge clk) #1;

    run_file(lines(8, 8), 1'b0);
    chk("t1_cnt", int'(cnt), 8);
    for (int k = 0; k < 8; k++) chk("t1_mem", int'(shadow[k]), k);

    run_file(lines(9, 8), 1'b1);
    chk("t2_cnt", int'(cnt), 8);
    chk("t2_ovf", int'(err_ovf), 1);
    chk("t2_mem7", int'(shadow[7]), 7);

    run_file(lines(7, 7), 1'b0);
    chk("t3_cnt", int'(cnt), 7);
    chk("t3_short", int'(err_short), 1);
    chk("t3_mem6", int'(shadow[6]), 6);
    chk("t3_mem7", int'(shadow[7]), 8'hAA);

    run_file("000000101\n00000011\n", 1'b0);
    chk("t4_cnt", int'(cnt), 1);
    chk("t4_long", int'(err_long), 1);
    chk("t4_mem0", int'(shadow[0]), 3);

    run_file("0000_0101\r\n0x000001\n11111111", 1'b0);
    chk("t5_cnt", int'(cnt), 2);
    chk("t5_char", int'(err_char), 1);
    chk("t5_mem0", int'(shadow[0]), 8'h05);
    chk("t5_mem1", int'(shadow[1]), 8'hFF);

    start_load();
    s = lines(3, 8);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    @(posedge clk) #1;
    chk("t6_pre_cnt", int'(cnt), 3);
    rst_n = 1'b0;
    expq.delete(); m_words = 0; m_es = 0; m_el = 0; m_ec = 0; m_eo = 0;
    model_clear_line(); m_active = 0; m_done_due = 32'h7fffffff;
    #1;
    chk("t6_we", int'(mem_we), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_cnt", int'(cnt), 0);
    chk("t6_rdy", int'(chr_rdy), 0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    run_file(lines(8, 8), 1'b0);
    chk("t6_reload_cnt", int'(cnt), 8);
    chk("t6_reload_mem0", int'(shadow[0]), 0);
    chk("t6_reload_mem5", int'(shadow[5]), 5);

    for (int f = 0; f < 25; f++) begin
      s = "";
      for (int l = $urandom_range(0, 11); l > 0; l--) begin
        for (int c = (($urandom_range(0, 5) == 0) ? 0 : $urandom_range(5, 10)); c > 0; c--) begin
          int r = $urandom_range(0, 39);
          t = " ";
          t[0] = r < 17 ? "0" : r < 34 ? "1" : r == 34 ? "_" : r == 35 ? "\r" :
                 r == 36 ? "\t" : r == 37 ? " " : r == 38 ? "x" : "Z";
          s = {s, t};
        end
        s = {s, "\n"};
      end
      if ($urandom_range(0, 1) == 0) s = {s, "1011"};
      if (s.len() == 0) s = "1";
      run_file(s, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("end_queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
